// File: rtl/modulo_sar7bits_pkg.sv
// Shared definitions for the successive-approximation search engine:
// trial-word width and the search state encoding.
package modulo_sar7bits_pkg;

  // Width of the trial word and of the recovered value (comparator is 7 bits).
  localparam int LARGURA = 7;

  // IDLE waits for start, TESTE runs one trial per cycle, FIM flags completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TESTE = 2'd1,
    FIM   = 2'd2
  } estado_t;

endpackage

// File: rtl/modulo_verifica_onehot3.sv
// Combinational check that exactly one of the three comparator flags is set.
module modulo_verifica_onehot3 (
  input  logic AltB,
  input  logic AeqB,
  input  logic AgtB,
  output logic valido
);

  logic [2:0] flags;
  logic [2:0] soEste;

  assign flags = {AltB, AeqB, AgtB};

  // soEste[gi] is high when flag gi is the only flag raised.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gSoEste
      assign soEste[gi] = flags[gi] & ~|(flags & ~(3'b001 << gi));
    end
  endgenerate

  assign valido = |soEste;

endmodule

// File: rtl/modulo_sar7bits.sv
// Successive-approximation search: drives trial words on B_out, reads the
// external comparator flags and recovers A one bit per cycle, MSB first.
module modulo_sar7bits #(
  parameter int LARGURA = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               AltB_in,
  input  logic               AeqB_in,
  input  logic               AgtB_in,
  output logic [LARGURA-1:0] B_out,
  output logic [LARGURA-1:0] resultado,
  output logic               busy,
  output logic               done,
  output logic               erro
);

  import modulo_sar7bits_pkg::*;

  localparam int IdxW = $clog2(LARGURA);

  estado_t            stateReg, stateNext;
  logic [LARGURA-1:0] bReg, bNext;
  logic [LARGURA-1:0] resReg, resNext;
  logic [IdxW-1:0]    idxReg, idxNext;
  logic               erroReg, erroNext;

  logic               valido;
  logic [LARGURA-1:0] bitAtual;   // one-hot mask of the bit under test
  logic [LARGURA-1:0] bitAbaixo;  // one-hot mask of the next lower bit
  logic [LARGURA-1:0] trial;      // current trial after applying this cycle's decision

  modulo_verifica_onehot3 uOnehot (
    .AltB   (AltB_in),
    .AeqB   (AeqB_in),
    .AgtB   (AgtB_in),
    .valido (valido)
  );

  // Decode the bit index into masks for the current and the next lower bit.
  genvar gi;
  generate
    for (gi = 0; gi < LARGURA; gi++) begin : gMask
      assign bitAtual[gi]  = (idxReg == IdxW'(gi));
      assign bitAbaixo[gi] = (idxReg == IdxW'(gi + 1));
    end
  endgenerate

  // A<B means the trial overshot, so the bit under test is dropped.
  assign trial = AltB_in ? (bReg & ~bitAtual) : bReg;

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
      bReg     <= '0;
      resReg   <= '0;
      idxReg   <= IdxW'(LARGURA - 1);
      erroReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      bReg     <= bNext;
      resReg   <= resNext;
      idxReg   <= idxNext;
      erroReg  <= erroNext;
    end
  end

  // Next-state and datapath update for one comparison per cycle.
  always_comb begin
    stateNext = stateReg;
    bNext     = bReg;
    resNext   = resReg;
    idxNext   = idxReg;
    erroNext  = erroReg;
    case (stateReg)
      IDLE: begin
        if (start) begin
          stateNext = TESTE;
          bNext     = {1'b1, {(LARGURA-1){1'b0}}};
          idxNext   = IdxW'(LARGURA - 1);
          erroNext  = 1'b0;
        end
      end
      TESTE: begin
        if (!valido) begin
          // Inconsistent comparator answer: abandon the search.
          erroNext  = 1'b1;
          resNext   = '0;
          stateNext = FIM;
        end else if (AeqB_in) begin
          // Exact hit: remaining lower bits are already zero in the trial.
          resNext   = bReg;
          stateNext = FIM;
        end else if (idxReg == '0) begin
          resNext   = trial;
          bNext     = trial;
          stateNext = FIM;
        end else begin
          bNext   = trial | bitAbaixo;
          idxNext = idxReg - 1'b1;
        end
      end
      FIM: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign B_out     = bReg;
  assign resultado = resReg;
  assign erro      = erroReg;
  assign busy      = (stateReg == TESTE);
  assign done      = (stateReg == FIM);

endmodule

// File: tb/tb_modulo_sar7bits.sv
// Closed-loop bench: a behavioural 7-bit comparator answers the DUT's trials,
// with an override path to inject inconsistent flag patterns.
module tb_modulo_sar7bits;

  logic       clk;
  logic       reset;
  logic       start;
  logic       AltB_in, AeqB_in, AgtB_in;
  logic [6:0] B_out;
  logic [6:0] resultado;
  logic       busy, done, erro;

  logic [6:0] aVal;
  logic       ovrEn;
  logic [2:0] ovrFlags;  // {lt, eq, gt}

  int errors = 0;
  int checks = 0;

  modulo_sar7bits #(.LARGURA(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .AltB_in   (AltB_in),
    .AeqB_in   (AeqB_in),
    .AgtB_in   (AgtB_in),
    .B_out     (B_out),
    .resultado (resultado),
    .busy      (busy),
    .done      (done),
    .erro      (erro)
  );

  assign AltB_in = ovrEn ? ovrFlags[2] : (aVal <  B_out);
  assign AeqB_in = ovrEn ? ovrFlags[1] : (aVal == B_out);
  assign AgtB_in = ovrEn ? ovrFlags[0] : (aVal >  B_out);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: trial j tests bit k=6-j with all higher bits of A already known.
  function automatic int expTrial(input int a, input int j);
    int k;
    k = 6 - j;
    return ((a >> (k + 1)) << (k + 1)) + (1 << k);
  endfunction

  // Reference: the search ends on the trial whose tested bit is A's lowest set bit.
  function automatic int expTrials(input int a);
    int tz;
    if (a == 0) return 7;
    tz = 0;
    while (((a >> tz) & 1) == 0) tz++;
    return 7 - tz;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // One full closed-loop search; the start edge counts as cycle 1.
  task automatic runSearch(input int a, input string tag);
    int  cyc, nBusy;
    bit  seen;
    aVal  = a[6:0];
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    cyc = 1; nBusy = 0; seen = 0;
    check({tag, "_erro_cleared"}, erro, 0);
    while (!seen && cyc < 20) begin
      if (busy) begin
        if (nBusy < 7) check({tag, "_trial"}, B_out, expTrial(a, nBusy));
        nBusy++;
      end
      stepCycle();
      cyc++;
      if (done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_done_cycle"}, cyc, expTrials(a) + 1);
    check({tag, "_busy_cycles"}, nBusy, expTrials(a));
    check({tag, "_resultado"}, resultado, a);
    check({tag, "_erro"}, erro, 0);
    $display("search %s A=%0d resultado=%0d done_cycle=%0d", tag, a, resultado, cyc);
    stepCycle();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  typedef struct {
    int a;
    int expRes;
    int expDone;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    bit seen;
    int nDone;
    int trials;
    logic busyArr[20];
    logic doneArr[20];
    logic [6:0] resArr[20];

    vecs[0] = '{85, 85, 8};
    vecs[1] = '{64, 64, 2};
    vecs[2] = '{0, 0, 8};
    vecs[3] = '{127, 127, 8};
    vecs[4] = '{96, 96, 3};
    vecs[5] = '{1, 1, 8};

    reset = 1'b1; start = 1'b0; aVal = '0; ovrEn = 1'b0; ovrFlags = '0;
    repeat (2) stepCycle();
    check("rst_B_out", B_out, 0);
    check("rst_resultado", resultado, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_erro", erro, 0);
    reset = 1'b0;
    stepCycle();

    // Table of directed vectors, including both boundaries and the best case.
    for (int i = 0; i < 6; i++) begin
      runSearch(vecs[i].a, "vec");
      check("vec_table_res", resultado, vecs[i].expRes);
      check("vec_table_lat", expTrials(vecs[i].a) + 1, vecs[i].expDone);
    end

    // Random closed-loop searches.
    for (int i = 0; i < 30; i++) begin
      runSearch(int'($urandom_range(0, 127)), "rnd");
    end

    // Two flags raised on the third trial -> erro, resultado cleared.
    aVal = 7'd85;
    start = 1'b1; stepCycle(); start = 1'b0;
    stepCycle(); stepCycle();
    check("err_trial3", B_out, expTrial(85, 2));
    ovrEn = 1'b1; ovrFlags = 3'b101;
    stepCycle();
    ovrEn = 1'b0;
    check("err_done", done, 1);
    check("err_erro", erro, 1);
    check("err_resultado", resultado, 0);
    $display("search err A=85 erro=%0d resultado=%0d", erro, resultado);
    stepCycle();
    check("err_sticky", erro, 1);
    check("err_idle_busy", busy, 0);
    runSearch(85, "after_err");

    // No flags at all on the first trial is also an error.
    start = 1'b1; stepCycle(); start = 1'b0;
    ovrEn = 1'b1; ovrFlags = 3'b000;
    stepCycle();
    ovrEn = 1'b0;
    check("none_done", done, 1);
    check("none_erro", erro, 1);
    check("none_resultado", resultado, 0);
    $display("search none-flags erro=%0d", erro);
    stepCycle();

    // start re-pulsed mid-search and during FIM must be ignored.
    aVal = 7'd85;
    start = 1'b1; stepCycle(); start = 1'b0;
    cyc = 1; seen = 0; nDone = 0;
    while (!seen && cyc < 20) begin
      start = (cyc == 3);
      stepCycle();
      cyc++;
      if (done) seen = 1;
    end
    start = 1'b0;
    check("mid_done_seen", seen, 1);
    check("mid_done_cycle", cyc, 8);
    check("mid_resultado", resultado, 85);
    $display("search mid-start A=85 resultado=%0d done_cycle=%0d", resultado, cyc);
    start = 1'b1;  // presented while in FIM
    stepCycle();
    start = 1'b0;
    check("fim_start_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      if (done || busy) nDone++;
    end
    check("mid_no_extra", nDone, 0);

    // Asynchronous reset at the fourth trial.
    aVal = 7'd85;
    start = 1'b1; stepCycle(); start = 1'b0;
    repeat (3) stepCycle();
    check("rst_mid_trial4", B_out, expTrial(85, 3));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_B_out", B_out, 0);
    check("rst_mid_resultado", resultado, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_erro", erro, 0);
    $display("reset mid-search B_out=%0d resultado=%0d busy=%0d", B_out, resultado, busy);
    stepCycle();
    reset = 1'b0;
    nDone = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (done || busy) nDone++;
    end
    check("rst_mid_quiet", nDone, 0);

    // start held high: back-to-back searches with a single idle cycle between.
    aVal = 7'd10;
    trials = expTrials(10);
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      busyArr[i] = busy;
      doneArr[i] = done;
      resArr[i]  = resultado;
    end
    start = 1'b0;
    nDone = 0;
    for (int i = 0; i < 20; i++) begin
      check("held_busy", busyArr[i], ((i % (trials + 2)) < trials) ? 1 : 0);
      check("held_done", doneArr[i], ((i % (trials + 2)) == trials) ? 1 : 0);
      if (doneArr[i]) begin
        nDone++;
        check("held_resultado", resArr[i], 10);
      end
    end
    check("held_done_count", nDone, 2);
    $display("held-start A=10 searches=%0d", nDone);
    cyc = 0;
    while (busy && cyc < 20) begin
      stepCycle();
      cyc++;
    end
    check("held_drain", busy, 0);
    repeat (3) stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
